mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage. Consumes the two register_file read

---
 rtl/mul_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: single-cycle multiply, 32-step restoring divide.
// Optional MDU_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration loop.
module mul_div_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [TAGW-1:0] in_rd,
  input  logic            kill,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_rd
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [TAGW-1:0] rd_q, rd_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [TAGW-1:0] out_rd_q, out_rd_d;

  logic               in_div_signed;
  logic               mul_sign_a, mul_sign_b;
  logic signed [XLEN:0] mul_a, mul_b;
  logic [PW-1:0]      prod;
  logic [XLEN:0]      div_shift, div_diff;
  logic               fix_signed, fix_dz, fix_ovf;
  logic [XLEN-1:0]    fix_quo, fix_rem;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE) && !kill;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;

  assign in_div_signed = !in_funct3[0];

  // 33-bit extension lets one signed multiplier cover all four variants
  assign mul_sign_a = (f3_q[1:0] == 2'b01) || (f3_q[1:0] == 2'b10);
  assign mul_sign_b = (f3_q[1:0] == 2'b01);
  assign mul_a      = {mul_sign_a && a_q[XLEN-1], a_q};
  assign mul_b      = {mul_sign_b && b_q[XLEN-1], b_q};
  assign prod       = PW'(mul_a) * PW'(mul_b);

  // One restoring step: a borrow out of the top bit means the trial subtract failed
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};

  assign fix_signed = !f3_q[0];
  assign fix_dz     = (b_q == '0);
  assign fix_ovf    = fix_signed && (a_q == INT_MIN) && (b_q == '1);

  always_comb begin
    fix_quo = (fix_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    fix_rem = (fix_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
    if (fix_dz) begin
      fix_quo = '1;
      fix_rem = a_q;
    end else if (fix_ovf) begin
      fix_quo = INT_MIN;
      fix_rem = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    a_d          = a_q;
    b_d          = b_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvs_d        = dvs_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;

    if (kill && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && !kill) begin
            f3_d    = in_funct3;
            rd_d    = in_rd;
            a_d     = in_rs1;
            b_d     = in_rs2;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = (in_div_signed && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
            dvs_d   = (in_div_signed && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
            state_d = in_funct3[2] ? S_DIV : S_MUL;
`ifdef MDU_EARLY_OUT_EN
            if (in_funct3[2] && ((in_rs2 == '0) ||
                (in_div_signed && (in_rs1 == INT_MIN) && (in_rs2 == '1)))) begin
              state_d = S_FIX;
            end
`endif
          end
        end
        S_MUL: begin
          out_result_d = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
          out_rd_d     = rd_q;
          state_d      = S_DONE;
        end
        S_DIV: begin
          if (div_diff[XLEN]) begin
            rem_d = div_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end else begin
            rem_d = div_diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          out_result_d = f3_q[1] ? fix_rem : fix_quo;
          out_rd_d     = rd_q;
          state_d      = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvs_q        <= '0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvs_q        <= dvs_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M vectors, random ops vs. an
// arithmetic reference model, kill/reset aborts and back-to-back issue.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        kill;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit #(.XLEN(32), .TAGW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics in plain 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return 2;
`ifdef MDU_EARLY_OUT_EN
    if (b == 32'd0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] pick [6];
    pick[0] = 32'd0;
    pick[1] = 32'd1;
    pick[2] = 32'hFFFF_FFFF;
    pick[3] = 32'h8000_0000;
    pick[4] = 32'($urandom_range(0, 20));
    pick[5] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return pick[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Issue one op, then measure latency, result, tag, busy and one-cycle pulse
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp_res;
    int exp_lat;
    int lat;
    logic busy_ok;
    exp_res = ref_result(f3, a, b);
    exp_lat = ref_latency(f3, a, b);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s ready_before: got %b expected 1", name, in_ready);
    else n_pass++;
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_funct3 = 3'($urandom); in_rs1 = $urandom; in_rs2 = $urandom;
    in_rd = 5'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (out_result !== exp_res)
      $display("FAIL %s result: got %h expected %h", name, out_result, exp_res);
    else n_pass++;
    n_checks++;
    if (out_rd !== rd) $display("FAIL %s rd: got %0d expected %0d", name, out_rd, rd);
    else n_pass++;
    n_checks++;
    if (!busy_ok) $display("FAIL %s busy: in_ready got 1 expected 0 while in flight", name);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== exp_res)
      $display("FAIL %s hold: got valid=%b result=%h expected valid=0 result=%h",
               name, out_valid, out_result, exp_res);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_result !== 32'd0) $display("FAIL reset_result: got %h expected 0", out_result);
    else n_pass++;
    n_checks++;
    if (out_rd !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", out_rd);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
  endtask

  task automatic test_div();
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd11);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd12);
  endtask

  task automatic test_div_special();
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd13);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd14);
    run_op("div_negby0", 3'd4, 32'hFFFF_FFF0, 32'd0, 5'd15);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             5'($urandom));
    end
  endtask

  task automatic test_kill();
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd4; in_rs1 = 32'd100; in_rs2 = 32'd7; in_rd = 5'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL kill_div_ready: got %b expected 1", in_ready);
    else n_pass++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL kill_div_novalid: got out_valid=1 expected none");
    else n_pass++;
    run_op("after_kill", 3'd5, 32'd9, 32'd3, 5'd4);

    // kill while the result is being presented
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd4; in_rd = 5'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL kill_done: got out_valid=%b expected 0", out_valid);
    else n_pass++;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL kill_done_idle: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;

    // kill with a request in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'd5; in_rs2 = 32'd5;
    @(posedge clk);
    #1 in_valid = 1'b0; kill = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL kill_idle_ready: got %b expected 1", in_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL kill_idle_novalid: got out_valid=1 expected none");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd0; in_rs1 = 32'd6; in_rs2 = 32'd7; in_rd = 5'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // request the second op during the result cycle; it must wait one edge
    in_valid = 1'b1; in_funct3 = 3'd3; in_rs1 = 32'hFFFF_FFFF; in_rs2 = 32'd2; in_rd = 5'd21;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd42)
      $display("FAIL b2b_first: got valid=%b result=%h expected 1/0000002a", out_valid, out_result);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != 2 || out_result !== 32'd1 || out_rd !== 5'd21)
      $display("FAIL b2b_second: got lat=%0d result=%h rd=%0d expected 2/00000001/21",
               lat, out_result, out_rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd4; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || in_ready !== 1'b1)
      $display("FAIL reset_mid: got valid=%b result=%h rd=%0d ready=%b expected 0/0/0/1",
               out_valid, out_result, out_rd, in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'd7, 32'd1000, 32'd3, 5'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0;
    in_funct3 = 3'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_rd = 5'd0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
